// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one asynchronous video SRAM between the display fetch
// path (priority reader) and the command write path. All SRAM strobes, the
// address/data registers and the data-bus direction control live here.
// Optional build macro VRAM_ARB_FAIR_EN adds a starve counter that forces a
// pending write through after STARVE_LIMIT back-to-back display grants.

module vram_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 3,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_doe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_nce,
    output logic              sram_noe,
    output logic              sram_nwe
);

    // state   | meaning
    // IDLE    | strobes idle, arbitrate on next unsuppressed cycle
    // READ    | nce/noe low, counting the access window
    // WRITE   | nce/nwe low with doe high, counting the access window
    // WR_HOLD | strobes released, bus still driven one cycle for data hold

    typedef enum logic [1:0] {IDLE, READ, WRITE, WR_HOLD} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] rdata_d;
    logic              doe_d, nce_d, noe_d, nwe_d;
    logic              disp_ack_d, wr_ack_d;
    logic              ack_busy;
    logic              force_wr;

    // The cycle an ack is visible the requester has not yet dropped its
    // request, so arbitration must sit that cycle out.
    assign ack_busy = disp_ack | wr_ack;

`ifdef VRAM_ARB_FAIR_EN
    localparam logic [3:0] STARVE_TC = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    assign force_wr = (starve_q == STARVE_TC) && disp_req && wr_req;

    // Starve counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_wr = 1'b0;
`endif

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = sram_addr;
        dout_d     = sram_dout;
        rdata_d    = disp_rdata;
        doe_d      = sram_doe;
        nce_d      = sram_nce;
        noe_d      = sram_noe;
        nwe_d      = sram_nwe;
        disp_ack_d = 1'b0;
        wr_ack_d   = 1'b0;
`ifdef VRAM_ARB_FAIR_EN
        starve_d   = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (!ack_busy) begin
                    if (disp_req && !force_wr) begin
                        addr_d  = disp_addr;
                        nce_d   = 1'b0;
                        noe_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = READ;
`ifdef VRAM_ARB_FAIR_EN
                        starve_d = wr_req ? starve_q + 4'd1 : 4'd0;
`endif
                    end else if (wr_req) begin
                        addr_d  = wr_addr;
                        dout_d  = wr_data;
                        doe_d   = 1'b1;
                        nce_d   = 1'b0;
                        nwe_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = WRITE;
`ifdef VRAM_ARB_FAIR_EN
                        starve_d = 4'd0;
`endif
                    end
                end
            end
            READ: begin
                if (cnt_q == LAST_CNT) begin
                    rdata_d    = sram_din;
                    disp_ack_d = 1'b1;
                    nce_d      = 1'b1;
                    noe_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                if (cnt_q == LAST_CNT) begin
                    nwe_d   = 1'b1;
                    nce_d   = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HOLD: begin
                doe_d    = 1'b0;
                wr_ack_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and SRAM-facing registers; reset releases strobes at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            disp_rdata <= '0;
            sram_doe   <= 1'b0;
            sram_nce   <= 1'b1;
            sram_noe   <= 1'b1;
            sram_nwe   <= 1'b1;
            disp_ack   <= 1'b0;
            wr_ack     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sram_addr  <= addr_d;
            sram_dout  <= dout_d;
            disp_rdata <= rdata_d;
            sram_doe   <= doe_d;
            sram_nce   <= nce_d;
            sram_noe   <= noe_d;
            sram_nwe   <= nwe_d;
            disp_ack   <= disp_ack_d;
            wr_ack     <= wr_ack_d;
        end
    end

`ifndef SYNTHESIS
    // Bus-safety invariants and parameter legality.
    a_no_oe_we: assert property (@(posedge clk) disable iff (!nrst)
        !(!sram_noe && !sram_nwe));
    a_no_contention: assert property (@(posedge clk) disable iff (!nrst)
        !(sram_doe && !sram_noe));
    a_one_ack: assert property (@(posedge clk) disable iff (!nrst)
        !(disp_ack && wr_ack));
    a_params: assert property (@(posedge clk)
        ACCESS_CYCLES >= 1 && ACCESS_CYCLES <= 15 &&
        STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15);
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural async SRAM model.
module tb_vram_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              nrst;
    logic              disp_req, wr_req;
    logic [ADDR_W-1:0] disp_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              disp_ack, wr_ack;
    logic [DATA_W-1:0] disp_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout, sram_din;
    logic              sram_doe, sram_nce, sram_noe, sram_nwe;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_chk = 0;
    int n_fail = 0;

    int noe_lo_cnt = 0, nwe_lo_cnt = 0, doe_hi_cnt = 0;
    int dack_cnt = 0, wack_cnt = 0, viol_cnt = 0;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(3), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .nrst(nrst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_ack(disp_ack), .disp_rdata(disp_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
        .sram_din(sram_din), .sram_nce(sram_nce), .sram_noe(sram_noe),
        .sram_nwe(sram_nwe)
    );

    always #5 clk = ~clk;

    // SRAM model: combinational read, write while nce/nwe low.
    assign sram_din = (!sram_nce && !sram_noe) ? mem[sram_addr] : 8'hFF;

    always @(posedge clk) begin
        if (!sram_nce && !sram_nwe && sram_doe) mem[sram_addr] <= sram_dout;
    end

    // Strobe activity and invariant monitor.
    always @(negedge clk) begin
        if (!sram_noe) noe_lo_cnt++;
        if (!sram_nwe) nwe_lo_cnt++;
        if (sram_doe)  doe_hi_cnt++;
        if (disp_ack)  dack_cnt++;
        if (wr_ack)    wack_cnt++;
        if ((!sram_noe && !sram_nwe) || (sram_doe && !sram_noe) || (disp_ack && wr_ack))
            viol_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Count negedges until the selected ack is seen; -1 if the bound expires.
    task automatic wait_ack(input int which, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && disp_ack) || (which == 1 && wr_ack)) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, s0, s1, s2, dl, wl, nd, first_wr, exp_wr, s_viol;
        logic [DATA_W-1:0] rd;

        nrst = 1'b0; disp_req = 1'b0; wr_req = 1'b0;
        disp_addr = '0; wr_addr = '0; wr_data = '0;
        mem[18'h00123] = 8'hA5;
        mem[18'h00010] = 8'h3C;
        repeat (3) @(negedge clk);

        chk("rst_nce", sram_nce, 1);
        chk("rst_noe", sram_noe, 1);
        chk("rst_nwe", sram_nwe, 1);
        chk("rst_doe", sram_doe, 0);
        chk("rst_acks", {disp_ack, wr_ack}, 0);
        chk("rst_rdata", disp_rdata, 0);
        chk("rst_addr", sram_addr, 0);
        nrst = 1'b1;
        s_viol = viol_cnt;

        // single read
        @(negedge clk);
        disp_addr = 18'h00123; disp_req = 1'b1;
        s0 = noe_lo_cnt; s1 = dack_cnt;
        wait_ack(0, 20, lat);
        chk("rd_lat", lat, 4);
        chk("rd_data", disp_rdata, 8'hA5);
        chk("rd_addr", sram_addr, 18'h00123);
        disp_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("rd_noe_cycles", noe_lo_cnt - s0, 3);
        chk("rd_ack_pulses", dack_cnt - s1, 1);

        // asynchronous reset between clock edges clears read data at once
        #2 nrst = 1'b0;
        #1;
        chk("arst_rdata", disp_rdata, 0);
        chk("arst_addr", sram_addr, 0);
        @(negedge clk);
        nrst = 1'b1;

        // single write at top address
        @(negedge clk);
        wr_addr = 18'h3FFFF; wr_data = 8'h5A; wr_req = 1'b1;
        s0 = nwe_lo_cnt; s1 = doe_hi_cnt; s2 = wack_cnt;
        wait_ack(1, 20, lat);
        chk("wr_lat", lat, 5);
        chk("wr_dout", sram_dout, 8'h5A);
        chk("wr_addr", sram_addr, 18'h3FFFF);
        wr_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("wr_nwe_cycles", nwe_lo_cnt - s0, 3);
        chk("wr_doe_cycles", doe_hi_cnt - s1, 4);
        chk("wr_ack_pulses", wack_cnt - s2, 1);
        chk("wr_mem", mem[18'h3FFFF], 8'h5A);

        // simultaneous requests: read first, write on first unsuppressed cycle
        @(negedge clk);
        disp_addr = 18'h00010; disp_req = 1'b1;
        wr_addr = 18'h00020; wr_data = 8'h77; wr_req = 1'b1;
        dl = -1; wl = -1; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (disp_ack && dl < 0) begin dl = i; rd = disp_rdata; disp_req = 1'b0; end
            if (wr_ack && wl < 0) begin wl = i; wr_req = 1'b0; end
            if (dl >= 0 && wl >= 0) break;
        end
        chk("sim_rd_lat", dl, 4);
        chk("sim_wr_lat", wl, 10);
        chk("sim_rd_data", rd, 8'h3C);
        repeat (2) @(negedge clk);
        chk("sim_wr_mem", mem[18'h00020], 8'h77);

        // starvation: display held continuously, write pending throughout
        @(negedge clk);
        disp_addr = 18'h00010; disp_req = 1'b1;
        wr_addr = 18'h00080; wr_data = 8'h99; wr_req = 1'b1;
        s2 = wack_cnt; nd = 0; first_wr = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (disp_ack) nd++;
            if (wr_ack && first_wr < 0) first_wr = nd;
            if (nd == 30) break;
        end
        disp_req = 1'b0; wr_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("starve_disp_acks", nd, 30);
`ifdef VRAM_ARB_FAIR_EN
        exp_wr = 7;
        chk("fair_first_wr", first_wr, 4);
`else
        exp_wr = 0;
`endif
        chk("starve_wr_acks", wack_cnt - s2, exp_wr);

        // reset during WRITE with cnt=1
        @(negedge clk);
        wr_addr = 18'h00055; wr_data = 8'hEE; wr_req = 1'b1;
        s2 = wack_cnt;
        repeat (2) @(negedge clk);
        chk("mid_wr_nwe_low", sram_nwe, 0);
        #1 nrst = 1'b0;
        #1;
        chk("mid_wr_nwe", sram_nwe, 1);
        chk("mid_wr_nce", sram_nce, 1);
        chk("mid_wr_doe", sram_doe, 0);
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_wr_no_ack", wack_cnt - s2, 0);

        // fresh write after recovery
        wr_addr = 18'h00042; wr_data = 8'h11; wr_req = 1'b1;
        wait_ack(1, 20, lat);
        chk("rec_wr_lat", lat, 5);
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rec_wr_mem", mem[18'h00042], 8'h11);

        chk("invariants", viol_cnt - s_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
